dest_event_buffer: RTL and testbench
====================================

Name: dest_event_buffer

Overview:
- Destination-domain consumer that sits directly downstream of cdc_handshake_ss.
- Each dest_strobe pulse is captured as an event, stamped with a free-running cycle counter, and queued in a small FIFO.
- Events drain to a local consumer over a valid/ready interface.
- Backpressure returns to the CDC handshake via dest_stall, with headroom for in-flight strobes.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- TS_WIDTH, 16, timestamp counter width in bits.
- STALL_THRESH, 6, occupancy at or above which dest_stall asserts; 1 <= STALL_THRESH <= DEPTH.

Ports:
- dest_clk  in  1  destination-domain clock; all logic on rising edge.
- dest_reset_n  in  1  asynchronous active-low reset.
- dest_strobe  in  1  single-cycle event pulse from cdc_handshake_ss.
- dest_stall  out  1  backpressure to cdc_handshake_ss, registered.
- evt_valid  out  1  head event available.
- evt_ready  in  1  consumer accepts head event.
- evt_timestamp  out  TS_WIDTH  timestamp of head event; valid only while evt_valid.
- evt_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a strobe was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset (async assert, sync release): timestamp counter, read pointer, write pointer and level are 0; dest_stall, evt_valid and overflow are 0; evt_timestamp is 0.
- Timestamp counter:
  - Increments by 1 every cycle out of reset.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Push:
  - A strobe at cycle N with level < DEPTH, or level == DEPTH with a pop in the same cycle, writes the counter value sampled at N.
  - A strobe with level == DEPTH and no pop is dropped, and overflow is set at N+1.
- Pop: when evt_valid && evt_ready, the head is removed.
- evt_valid equals (level != 0). Output is FIFO-registered, so there is no same-cycle bypass.
- Latency: strobe at N into an empty buffer gives evt_valid = 1 at N+1, with evt_timestamp equal to the counter value at N.
- Simultaneous push and pop:
  - Level is unchanged and both pointers advance.
  - When empty, no pop is possible; the push lands and level becomes 1.
- Level update: level_next = level + push_accepted - pop. Pointers are log2(DEPTH) bits and wrap naturally.
- dest_stall:
  - Registered; dest_stall(N+1) = (level_next(N) >= STALL_THRESH).
  - Headroom of DEPTH-STALL_THRESH entries absorbs strobes already in flight through the handshake.
- overflow:
  - Set on a dropped strobe; cleared by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- Data hold: evt_timestamp and evt_valid stay stable while evt_valid && !evt_ready.
- Reset mid-operation flushes all entries immediately; events in flight are lost, which is permitted.
- Strobes on consecutive cycles are each separate events; there is no merging.

Test Plan:
- Reset, then a single strobe at counter value 5 with evt_ready = 1: evt_valid high for exactly 1 cycle with evt_timestamp = 5; evt_level goes 0 -> 1 -> 0; dest_stall stays 0.
- evt_ready = 0 with strobes on 6 consecutive cycles starting at counter value 10: level reaches 6, dest_stall asserts the cycle after the 6th strobe. Then raise evt_ready: timestamps 10..15 pop in order, and dest_stall deasserts once level < 6.
- evt_ready = 0 with 9 strobes: level saturates at 8, the 9th strobe is dropped and overflow = 1. After draining, exactly 8 timestamps are seen. clear_overflow returns overflow to 0.
- Full buffer, a strobe and a pop in the same cycle: level stays 8, overflow stays 0, and the new timestamp appears last in drain order.
- With TS_WIDTH = 4, strobes at counter values 14, 15 and 0 (post-wrap): timestamps read 14, 15, 0.
- dest_reset_n pulsed low for 1 cycle with 4 entries queued: evt_valid, evt_level, dest_stall and overflow read 0 immediately, and the counter restarts from 0.

Source files
------------

// File: rtl/dest_event_buffer.sv
// Destination-side event buffer: timestamps each dest_strobe and queues it
// for a valid/ready consumer, with registered stall back to the CDC handshake.
module dest_event_buffer #(
  parameter int DEPTH        = 8,
  parameter int TS_WIDTH     = 16,
  parameter int STALL_THRESH = 6
) (
  input  logic                     dest_clk,
  input  logic                     dest_reset_n,
  input  logic                     dest_strobe,
  output logic                     dest_stall,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_WIDTH-1:0]      evt_timestamp,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [LW-1:0]       level;
  logic [LW-1:0]       level_next;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  assign full      = (level == LW'(DEPTH));
  assign evt_valid = (level != '0);
  assign pop       = evt_valid & evt_ready;
  // a pop frees the head slot this cycle, so a full buffer still accepts
  assign push      = dest_strobe & (~full | pop);
  assign drop      = dest_strobe & full & ~pop;

  always_comb begin
    level_next = level + LW'(push) - LW'(pop);
  end

  assign evt_level     = level;
  assign evt_timestamp = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      ts_cnt     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      dest_stall <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ts_cnt     <= ts_cnt + TS_WIDTH'(1);
      level      <= level_next;
      dest_stall <= (level_next >= LW'(STALL_THRESH));
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge dest_clk) begin
    if (push)
      mem[wr_ptr] <= ts_cnt;
  end

endmodule

// File: tb/tb_dest_event_buffer.sv
// Randomized and directed bench for dest_event_buffer against a
// queue-based model of the event buffer.
module tb_dest_event_buffer;

  localparam int DEPTH = 8;
  localparam int TSW   = 4;
  localparam int THR   = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           strobe;
  logic           stall;
  logic           valid;
  logic           ready;
  logic [TSW-1:0] ts;
  logic [3:0]     level;
  logic           ovf;
  logic           clr;

  int n_tests = 0;
  int n_fail  = 0;

  int m_q[$];
  int m_cnt;
  bit m_ovf;
  bit m_stall;

  always #5 clk = ~clk;

  dest_event_buffer #(
    .DEPTH(DEPTH),
    .TS_WIDTH(TSW),
    .STALL_THRESH(THR)
  ) dut (
    .dest_clk(clk),
    .dest_reset_n(rst_n),
    .dest_strobe(strobe),
    .dest_stall(stall),
    .evt_valid(valid),
    .evt_ready(ready),
    .evt_timestamp(ts),
    .evt_level(level),
    .overflow(ovf),
    .clear_overflow(clr)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt   = 0;
    m_ovf   = 0;
    m_stall = 0;
  endtask

  task automatic check_all();
    chk("valid", int'(valid), int'(m_q.size() != 0));
    chk("level", int'(level), m_q.size());
    chk("ts", int'(ts), (m_q.size() != 0) ? m_q[0] : 0);
    chk("stall", int'(stall), int'(m_stall));
    chk("ovf", int'(ovf), int'(m_ovf));
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input bit s, input bit r, input bit c);
    bit do_pop;
    bit do_push;
    check_all();
    strobe = s;
    ready  = r;
    clr    = c;
    @(posedge clk);
    do_pop  = r && (m_q.size() != 0);
    do_push = s && (m_q.size() < DEPTH || do_pop);
    if (do_pop)
      void'(m_q.pop_front());
    if (do_push)
      m_q.push_back(m_cnt);
    if (s && !do_push)
      m_ovf = 1;
    else if (c)
      m_ovf = 0;
    m_stall = (m_q.size() >= THR);
    m_cnt   = (m_cnt + 1) % (1 << TSW);
    @(negedge clk);
    strobe = 0;
    clr    = 0;
  endtask

  task automatic idle_until(input int cnt);
    for (int i = 0; i < 20 && m_cnt != cnt; i++)
      step(0, 1, 0);
    chk("align_cnt", m_cnt, cnt);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++)
      step(0, 1, 0);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_valid", int'(valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ts", int'(ts), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n  = 0;
    strobe = 0;
    ready  = 0;
    clr    = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;

    // single event through an empty buffer
    idle_until(5);
    step(1, 1, 0);
    chk("t1_valid", int'(valid), 1);
    chk("t1_ts", int'(ts), 5);
    chk("t1_level", int'(level), 1);
    step(0, 1, 0);
    chk("t1_empty", int'(valid), 0);
    step(0, 1, 0);

    // stall threshold and ordered drain
    idle_until(10);
    for (int i = 0; i < 6; i++)
      step(1, 0, 0);
    chk("t2_level", int'(level), 6);
    chk("t2_stall", int'(stall), 1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_order", int'(ts), 10 + i);
      step(0, 1, 0);
    end
    chk("t2_unstall", int'(stall), 0);

    // overflow on the ninth strobe, then clear
    for (int i = 0; i < 9; i++)
      step(1, 0, 0);
    chk("t3_level", int'(level), 8);
    chk("t3_ovf", int'(ovf), 1);
    drain();
    step(0, 1, 1);
    chk("t3_clr", int'(ovf), 0);

    // full buffer, push and pop together
    for (int i = 0; i < 8; i++)
      step(1, 0, 0);
    step(1, 1, 0);
    chk("t4_level", int'(level), 8);
    chk("t4_ovf", int'(ovf), 0);
    drain();

    // counter wrap
    idle_until(14);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0);
    chk("t5_ts14", int'(ts), 14);
    step(0, 1, 0);
    chk("t5_ts15", int'(ts), 15);
    step(0, 1, 0);
    chk("t5_ts0", int'(ts), 0);
    drain();

    // reset with entries queued; counter restarts
    for (int i = 0; i < 4; i++)
      step(1, 0, 0);
    reset_pulse();
    step(1, 0, 0);
    chk("t6_ts0", int'(ts), 0);
    drain();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int mode;
      mode = (i / 250) % 3;
      step(($urandom_range(0, 3) < (mode == 0 ? 3 : 1)),
           ($urandom_range(0, 3) < (mode == 1 ? 3 : 1)),
           ($urandom_range(0, 7) == 0));
      if (i == 777)
        reset_pulse();
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
